// File: rtl/out_port_arbiter_pkg.sv
// Shared definitions for the output-port arbiter: flit type codes, default widths and FSM states.
package out_port_arbiter_pkg;

    localparam int unsigned TYPEW         = 2;
    localparam int unsigned PORTS_DEFAULT = 5;

    typedef enum logic [1:0] {
        TYPE_NONE = 2'b00,
        TYPE_HEAD = 2'b01,
        TYPE_DATA = 2'b10,
        TYPE_TAIL = 2'b11
    } flit_type_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } arb_state_e;

endpackage

// File: rtl/out_port_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping modulo PORTS.
module rr_pick #(
    parameter int unsigned PORTS = 5,
    parameter int unsigned PTRW  = (PORTS > 1) ? $clog2(PORTS) : 1
) (
    input  logic [PORTS-1:0] req,
    input  logic [PTRW-1:0]  ptr,
    output logic [PORTS-1:0] gnt,
    output logic [PTRW-1:0]  idx
);

    logic            found;
    logic [PTRW-1:0] pos;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        pos   = '0;
        for (int unsigned k = 0; k < PORTS; k++) begin
            pos = PTRW'((32'(ptr) + k) % PORTS);
            if (!found && req[pos]) begin
                found    = 1'b1;
                gnt[pos] = 1'b1;
                idx      = pos;
            end
        end
    end

endmodule

// File: rtl/out_port_arbiter.sv
// Packet-level round-robin arbiter driving the output mux select; holds a grant from HEAD to TAIL.
// Optional stall watchdog enabled by defining OUT_ARB_TIMEOUT_EN.
module out_port_arbiter #(
    parameter int unsigned PORTS   = out_port_arbiter_pkg::PORTS_DEFAULT,
    parameter int unsigned TYPEW   = out_port_arbiter_pkg::TYPEW,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [PORTS-1:0]       ivalid,
    input  logic [PORTS*TYPEW-1:0] itype,
    input  logic                   ordy,
    output logic [PORTS-1:0]       sel,
    output logic [PORTS-1:0]       ack,
    output logic                   busy,
    output logic                   err
);
    import out_port_arbiter_pkg::*;

    localparam int unsigned PTRW = (PORTS > 1) ? $clog2(PORTS) : 1;

    if (TIMEOUT == 0 || PORTS == 0) begin : g_bad_params
        $error("out_port_arbiter: PORTS and TIMEOUT must be non-zero");
    end

    arb_state_e       state_q, state_d;
    logic [PORTS-1:0] sel_q, sel_d;
    logic [PTRW-1:0]  ptr_q, ptr_d;
    logic             busy_q, busy_d;

    logic [PORTS-1:0] head_req, gnt, ack_c;
    logic [PTRW-1:0]  win_idx;
    logic [TYPEW-1:0] owner_type;
    logic             owner_valid, tail_ack, wd_fire;

    always_comb begin
        head_req   = '0;
        owner_type = '0;
        for (int unsigned i = 0; i < PORTS; i++) begin
            head_req[i] = ivalid[i] && (itype[i*TYPEW +: TYPEW] == TYPEW'(TYPE_HEAD));
            if (sel_q[i]) begin
                owner_type = owner_type | itype[i*TYPEW +: TYPEW];
            end
        end
    end

    rr_pick #(
        .PORTS (PORTS),
        .PTRW  (PTRW)
    ) u_rr_pick (
        .req (head_req),
        .ptr (ptr_q),
        .gnt (gnt),
        .idx (win_idx)
    );

    assign owner_valid = |(sel_q & ivalid);
    assign ack_c       = (state_q == ST_LOCK && ordy) ? (sel_q & ivalid) : '0;
    assign tail_ack    = (|ack_c) && (owner_type == TYPEW'(TYPE_TAIL));

`ifdef OUT_ARB_TIMEOUT_EN
    localparam int unsigned WDW = $clog2(TIMEOUT + 1);

    logic [WDW-1:0] wd_q, wd_d;
    logic           err_q, err_d;

    // Only owner-invalid cycles count; a backpressured owner (ordy low) keeps the count at zero.
    always_comb begin
        wd_d    = '0;
        wd_fire = 1'b0;
        if (state_q == ST_LOCK && !owner_valid) begin
            wd_d    = wd_q + 1'b1;
            wd_fire = (wd_q == WDW'(TIMEOUT - 1));
        end
        err_d = err_q | wd_fire;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            wd_q  <= wd_d;
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign wd_fire = 1'b0;
    assign err     = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        busy_d  = busy_q;
        unique case (state_q)
            ST_IDLE: begin
                if (|head_req) begin
                    state_d = ST_LOCK;
                    sel_d   = gnt;
                    busy_d  = 1'b1;
                    ptr_d   = (win_idx == PTRW'(PORTS - 1)) ? '0 : win_idx + 1'b1;
                end
            end
            ST_LOCK: begin
                if (tail_ack || wd_fire) begin
                    state_d = ST_IDLE;
                    sel_d   = '0;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                sel_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            ptr_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            busy_q  <= busy_d;
        end
    end

    assign sel  = sel_q;
    assign ack  = ack_c;
    assign busy = busy_q;

endmodule

// File: doc/out_port_arbiter.md
# out_port_arbiter

Per-output-port packet arbiter that generates the one-hot `sel` driving the router output mux. It sits directly upstream of the mux in the router datapath. It picks one of the input ports presenting a HEAD flit, round-robin, and holds the selection until that port's TAIL flit has transferred. It returns per-port flit acknowledges to the input buffers and honours a downstream ready signal.

## Interface
- `PORTS`, default 5: number of input ports; width of `sel`, `ivalid`, `ack`.
- `TYPEW`, default 2: width of the flit type field.
- `TIMEOUT`, default 64: stall watchdog limit in cycles; used only with `OUT_ARB_TIMEOUT_EN`.

Ports (clock and reset first):
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `ivalid`  in  PORTS  per-port flit-valid from the input buffers.
- `itype`  in  PORTS*TYPEW  per-port flit type, port i at bits [i*TYPEW +: TYPEW].
- `ordy`  in  1  downstream can accept a flit this cycle.
- `sel`  out  PORTS  one-hot mux select (registered); all-zero means no owner.
- `ack`  out  PORTS  combinational; a flit on port i is consumed this cycle.
- `busy`  out  1  registered; high while a packet owns the output.
- `err`  out  1  registered, sticky until reset; watchdog fired.

## Operation
- States:
  - IDLE: `sel`=0, `busy`=0.
  - LOCK: `sel`=onehot(owner), `busy`=1.
- Eligible port in IDLE: `ivalid[i]`=1 and `itype[i]`==TYPE_HEAD.
  - A port presenting DATA, TAIL or NONE in IDLE is not eligible and is never granted.
- IDLE to LOCK, on any eligible port:
  - Winner is the first eligible port scanning from `ptr` upward, wrapping modulo PORTS.
  - Register `sel`=onehot(winner); set `ptr`=(winner+1) mod PORTS.
  - `ordy` does not gate arbitration.
- In LOCK, `ack[i]` = `sel[i]` & `ivalid[i]` & `ordy`.
  - `ack` is always 0 in IDLE.
  - At most one `ack` bit is high in any cycle.
- LOCK to IDLE: the cycle where `ack[owner]`=1 and `itype[owner]`==TYPE_TAIL.
  - `sel` becomes 0 on the following edge.
- While in LOCK, `ivalid[owner]`=0 or `ordy`=0 means no transfer. State and `sel` are held indefinitely, except under the watchdog.
- Other ports' requests during LOCK are ignored. They are re-evaluated in the next IDLE cycle.

## Timing
- Reset values: `sel`=0, `ack`=0, `busy`=0, `err`=0, `ptr`=0, state IDLE.
- Assertion of `rst` mid-packet aborts the packet immediately. No TAIL is required.
- Arbitration latency: HEAD visible in IDLE at cycle t, then `sel` valid and HEAD transferable at cycle t+1 if `ordy`=1.
- There is exactly one IDLE bubble cycle between consecutive packets, including re-grants to the same port.
- When a TAIL is acked at cycle t, `sel`=0 at t+1, and the earliest new grant is visible at t+2.
- `ack` has zero latency from `ivalid`/`ordy`. This is the only combinational output.

## Configuration
- Macro `OUT_ARB_TIMEOUT_EN`.
- With the macro defined:
  - A counter tracks consecutive LOCK cycles with `ivalid[owner]`=0.
  - It resets to 0 on any owner-valid cycle or on entering LOCK.
  - When the count reaches `TIMEOUT`, the state forces to IDLE, `sel` goes to 0 on the next edge, and `err` is set.
  - `ptr` is unchanged by a timeout.
- Without the macro: no counter, `err` is tied 0, and LOCK is held indefinitely.
- `ordy`=0 stalls never count toward the timeout.

## Structure
- Shared define package holds:
  - flit type codes: TYPE_NONE=2'b00, TYPE_HEAD=2'b01, TYPE_DATA=2'b10, TYPE_TAIL=2'b11;
  - TYPEW;
  - the default PORTS.
- One sub-module, `rr_pick`: purely combinational round-robin priority picker.
  - Inputs: request vector and `ptr`.
  - Outputs: one-hot grant and winner index.
- The FSM, `ptr`, and the watchdog live in `out_port_arbiter`.

## Test plan
- Reset, then port 1 sends HEAD+20 DATA+TAIL with `ordy`=1:
  - `sel`=5'b00010 one cycle after the HEAD;
  - 22 consecutive `ack[1]` pulses;
  - `sel`=0 the cycle after the TAIL ack;
  - `ptr`=2.
- Ports 0, 2 and 4 all assert HEAD simultaneously from `ptr`=0, each sending 3-flit packets:
  - grant order is 0, 2, 4;
  - one bubble between packets.
- `ordy` toggles 1,0,1,0 during a port-3 packet:
  - `ack[3]` only in `ordy`=1 cycles;
  - `sel` is held throughout;
  - no extra flits are consumed.
- Port 2 presents a DATA flit while IDLE: never granted, `sel` stays 0.
  - Port 2 then presents HEAD: granted next cycle.
- `rst` asserted mid-packet at flit 10: all outputs are 0 immediately.
  - After release, a new HEAD on port 4 is granted, with the scan starting from port 0.
- With `OUT_ARB_TIMEOUT_EN` and `TIMEOUT`=64, owner port 1 drops `ivalid` after its HEAD:
  - `sel`=0 and `err`=1 after 64 idle-owner cycles;
  - a pending port-2 HEAD is granted afterwards.
